regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (we/addr/data, written on the negative clock edge) between two requesters.
- Requester 1 is the pipeline writeback stage, which has priority. Requester 2 is the long-latency unit (LLU: mul/div), whose results go through a small FIFO.
- Keeps a 32-entry pending-write scoreboard for LLU destinations and drives hazard_o to the issue stage.
- Asserts stall_o when the LLU FIFO is starved, so the FIFO can drain.

Parameters:
- DEPTH, 2, LLU result FIFO entries (power of 2, at least 2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may be denied the port before stall_o is asserted.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wb_we_i  in  1  writeback write request.
- wb_addr_i  in  5  writeback destination register.
- wb_data_i  in  32  writeback data.
- wb_grant_o  out  1  writeback write performed this cycle.
- llu_valid_i  in  1  LLU result valid.
- llu_addr_i  in  5  LLU destination register.
- llu_data_i  in  32  LLU result.
- llu_ready_o  out  1  FIFO can accept a result (registered count < DEPTH).
- issue_i  in  1  LLU op issued; mark its rd as pending.
- issue_rd_i  in  5  rd of the issued LLU op.
- rs_addr_i  in  5  issue-stage source register 1.
- rt_addr_i  in  5  issue-stage source register 2.
- hazard_o  out  1  pending[rs_addr_i] | pending[rt_addr_i] (combinational).
- stall_o  out  1  registered starvation stall request to the pipeline.
- rf_we_o  out  1  register-file write enable.
- rf_addr_o  out  5  register-file write address.
- rf_data_o  out  32  register-file write data.
- buf_count_o  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset, while rst_i is high and on the cycle after:
  - FIFO empty, buf_count_o = 0, all pending bits = 0, starve counter = 0, stall_o = 0.
  - llu_ready_o = 0 while rst_i is high, 1 afterwards.
  - rf_we_o = 0 and wb_grant_o = 0 while rst_i is high.
- Write-port grant is combinational, within the same cycle. Priority, highest first:
  - (a) stall_o = 1 and FIFO non-empty: FIFO head is written and popped. wb_we_i is ignored and wb_grant_o = 0.
  - (b) wb_we_i = 1 and wb_addr_i != 0: writeback is written and wb_grant_o = 1.
  - (c) FIFO non-empty: head is written and popped.
  - (d) Otherwise rf_we_o = 0, subject to the optional feature.
- Register 0:
  - wb_we_i with wb_addr_i = 0 is dropped and does not consume the port, so (c) may proceed. wb_grant_o = 1 (the request completes).
  - An LLU result to register 0 is accepted into the FIFO but never asserts rf_we_o. Its pop still occurs.
- FIFO push: llu_valid_i & llu_ready_o. Push and pop in the same cycle are allowed; occupancy is unchanged. Pointers wrap modulo DEPTH.
- Scoreboard:
  - On issue_i with issue_rd_i != 0, pending[issue_rd_i] is set.
  - It is cleared in the cycle an LLU result for that register is written to the port.
  - If set and clear hit the same register in the same cycle, set wins.
  - pending[0] is always 0.
  - WAW ordering between writeback and LLU is the pipeline's responsibility; the arbiter never reorders.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and not popped, and clears on any pop or when the FIFO is empty.
  - stall_o is set on the edge where the counter reaches STARVE_LIMIT. It clears on the edge after the first pop.
  - While stall_o = 1 the pipeline must hold its writeback values.
- Reset asserted mid-operation discards FIFO contents and pending bits, with no write on the reset cycle.

Optional Feature:
- REGARB_LLU_BYPASS_EN defined:
  - In case (d), when the FIFO is empty and llu_valid_i = 1, the LLU result is written directly to the port in the same cycle and is not pushed.
  - The pending bit clears as for a FIFO write.
- REGARB_LLU_BYPASS_EN undefined:
  - Every LLU result is pushed. Minimum latency from llu_valid_i to rf_we_o is 1 cycle.

Test Plan:
- Reset, then idle: rf_we_o = 0, stall_o = 0, llu_ready_o = 1, buf_count_o = 0, hazard_o = 0 for rs = 5, rt = 6.
- LLU result r8 = 0x0000_00AA with writeback idle:
  - Bypass build: rf_we_o = 1, addr 8, same cycle.
  - Non-bypass build: buf_count_o = 1, then write next cycle.
- Writeback writes to r3 every cycle, and an LLU result to r9 arrives:
  - FIFO holds r9 for 4 cycles, then stall_o = 1.
  - Next cycle r9 is written and wb_grant_o = 0.
  - stall_o drops one cycle later.
- issue_i with rd = 12, then rs_addr_i = 12: hazard_o = 1 until the LLU write of r12 completes, then 0 the following cycle.
- DEPTH = 2: two LLU pushes while writeback busy → llu_ready_o = 0. A third llu_valid_i is not accepted; count stays at 2.
- wb_we_i with addr 0 and FIFO head r4: r4 is written the same cycle, and wb_grant_o = 1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single register-file write port between the pipeline
//            writeback stage (priority requester) and a long-latency unit
//            (mul/div) whose results are buffered in a small FIFO. Keeps a
//            32-entry pending-write scoreboard for LLU destinations and raises
//            a registered stall when the FIFO is starved of the port.
// Optional : REGARB_LLU_BYPASS_EN -- when defined, an LLU result arriving with
//            the FIFO empty and the port otherwise idle is written straight
//            through in the same cycle instead of being buffered.
// Ports    :
//   clk_i, rst_i                 clock, synchronous active-high reset
//   wb_we_i/wb_addr_i/wb_data_i  writeback write request
//   wb_grant_o                   writeback request completed this cycle
//   llu_valid_i/addr/data        LLU result offered to the FIFO
//   llu_ready_o                  FIFO can accept a result
//   issue_i/issue_rd_i           LLU op issued, mark rd pending
//   rs_addr_i/rt_addr_i          issue-stage sources checked for hazards
//   hazard_o                     a source register has a pending LLU write
//   stall_o                      registered starvation stall request
//   rf_we_o/rf_addr_o/rf_data_o  register-file write port
//   buf_count_o                  FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_we_i,
  input  logic [4:0]                   wb_addr_i,
  input  logic [31:0]                  wb_data_i,
  output logic                         wb_grant_o,
  input  logic                         llu_valid_i,
  input  logic [4:0]                   llu_addr_i,
  input  logic [31:0]                  llu_data_i,
  output logic                         llu_ready_o,
  input  logic                         issue_i,
  input  logic [4:0]                   issue_rd_i,
  input  logic [4:0]                   rs_addr_i,
  input  logic [4:0]                   rt_addr_i,
  output logic                         hazard_o,
  output logic                         stall_o,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_addr_o,
  output logic [31:0]                  rf_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int STV_W = $clog2(STARVE_LIMIT+1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      pending;
  logic [STV_W-1:0] starve_cnt;
  logic             stall;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             fifo_empty;
  logic             fifo_full;
  logic [4:0]       head_addr;
  logic [31:0]      head_data;
  logic             pop;
  logic             push;
  logic             bypass;
  logic             llu_write;
  logic [4:0]       llu_write_addr;
  logic [31:0]      clr_mask;
  logic [31:0]      set_mask;
  logic [31:0]      pending_next;
  logic [STV_W-1:0] starve_next;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  assign llu_ready_o = !rst_i && !fifo_full;
  assign buf_count_o = count;
  assign stall_o     = stall;
  assign hazard_o    = pending[rs_addr_i] | pending[rt_addr_i];

  // --------------------------------------------------------------------------
  // Write-port arbitration (same-cycle). A starved FIFO beats writeback; a
  // writeback to r0 is completed without using the port so a buffered LLU
  // result can still go out in that cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    pop            = 1'b0;
    bypass         = 1'b0;
    wb_grant_o     = 1'b0;
    rf_we_o        = 1'b0;
    rf_addr_o      = '0;
    rf_data_o      = '0;
    llu_write      = 1'b0;
    llu_write_addr = '0;

    if (!rst_i) begin
      if (stall && !fifo_empty) begin
        pop = 1'b1;
      end else if (wb_we_i && (wb_addr_i != 5'd0)) begin
        wb_grant_o = 1'b1;
        rf_we_o    = 1'b1;
        rf_addr_o  = wb_addr_i;
        rf_data_o  = wb_data_i;
      end else begin
        wb_grant_o = wb_we_i;
        if (!fifo_empty) begin
          pop = 1'b1;
`ifdef REGARB_LLU_BYPASS_EN
        end else if (llu_valid_i) begin
          bypass = 1'b1;
`endif
        end
      end

      // An LLU result for r0 still leaves the FIFO but never strobes the port.
      if (pop) begin
        rf_we_o        = (head_addr != 5'd0);
        rf_addr_o      = head_addr;
        rf_data_o      = head_data;
        llu_write      = 1'b1;
        llu_write_addr = head_addr;
      end

      if (bypass) begin
        rf_we_o        = (llu_addr_i != 5'd0);
        rf_addr_o      = llu_addr_i;
        rf_data_o      = llu_data_i;
        llu_write      = 1'b1;
        llu_write_addr = llu_addr_i;
      end
    end
  end

  // A bypassed result has already been written, so it is not buffered.
  assign push = llu_valid_i && llu_ready_o && !bypass;

  // --------------------------------------------------------------------------
  // Scoreboard: set is applied after clear so a same-cycle set wins; bit 0 is
  // hard-wired low because r0 can never hold a result.
  // --------------------------------------------------------------------------
  assign clr_mask = llu_write ? (32'd1 << llu_write_addr) : 32'd0;
  assign set_mask = (issue_i && (issue_rd_i != 5'd0)) ? (32'd1 << issue_rd_i) : 32'd0;

  always_comb begin
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Starvation: count cycles a non-empty FIFO is refused the port. The counter
  // saturates; in practice a stall forces a pop before it could go further.
  // --------------------------------------------------------------------------
  always_comb begin
    if (pop || fifo_empty) begin
      starve_next = '0;
    end else if (starve_cnt == STV_W'(STARVE_LIMIT)) begin
      starve_next = starve_cnt;
    end else begin
      starve_next = starve_cnt + STV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      pending    <= '0;
      starve_cnt <= '0;
      stall      <= 1'b0;
    end else begin
      // Power-of-two depth: natural pointer overflow wraps modulo DEPTH.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      pending    <= pending_next;
      starve_cnt <= starve_next;

      if (pop) begin
        stall <= 1'b0;
      end else if (starve_next == STV_W'(STARVE_LIMIT)) begin
        stall <= 1'b1;
      end
    end
  end

  // FIFO storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= llu_addr_i;
      fifo_data[wr_ptr] <= llu_data_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Self-checking bench for regfile_write_arbiter: a directed vector
//            table, a short hand-written latency sequence, then randomized
//            traffic compared with a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_write_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CW           = $clog2(DEPTH+1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wb_we_i;
  logic [4:0]    wb_addr_i;
  logic [31:0]   wb_data_i;
  logic          wb_grant_o;
  logic          llu_valid_i;
  logic [4:0]    llu_addr_i;
  logic [31:0]   llu_data_i;
  logic          llu_ready_o;
  logic          issue_i;
  logic [4:0]    issue_rd_i;
  logic [4:0]    rs_addr_i;
  logic [4:0]    rt_addr_i;
  logic          hazard_o;
  logic          stall_o;
  logic          rf_we_o;
  logic [4:0]    rf_addr_o;
  logic [31:0]   rf_data_o;
  logic [CW-1:0] buf_count_o;

  always #5 clk_i = ~clk_i;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_grant_o(wb_grant_o),
    .llu_valid_i(llu_valid_i), .llu_addr_i(llu_addr_i), .llu_data_i(llu_data_i), .llu_ready_o(llu_ready_o),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .hazard_o(hazard_o), .stall_o(stall_o),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o), .buf_count_o(buf_count_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table: one row per clock cycle
  // --------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic        wb_we;  logic [4:0] wb_addr;  logic [31:0] wb_data;
    logic        llu_v;  logic [4:0] llu_addr; logic [31:0] llu_data;
    logic        issue;  logic [4:0] issue_rd; logic [4:0]  rs;
    logic        chk_state;
    logic        e_we;   logic [4:0] e_addr;   logic [31:0] e_data;
    logic        e_grant; logic e_ready; logic e_stall; int e_count; logic e_hazard;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic is, input logic [4:0] ird, input logic [4:0] rs, input logic cs,
    input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
    input logic eg, input logic er, input logic es, input int ec, input logic eh);
    vec_t v;
    v.rst = rst; v.wb_we = wbw; v.wb_addr = wba; v.wb_data = wbd;
    v.llu_v = lv; v.llu_addr = la; v.llu_data = ld;
    v.issue = is; v.issue_rd = ird; v.rs = rs; v.chk_state = cs;
    v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
    v.e_grant = eg; v.e_ready = er; v.e_stall = es; v.e_count = ec; v.e_hazard = eh;
    return v;
  endfunction

  vec_t vecs[23];

  task automatic set_idle();
    rst_i = 0; wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0;
    llu_valid_i = 0; llu_addr_i = 0; llu_data_i = 0;
    issue_i = 0; issue_rd_i = 0; rs_addr_i = 5; rt_addr_i = 6;
  endtask

  // --------------------------------------------------------------------------
  // Behavioural reference model: FIFO as a queue, scoreboard as a bit array
  // --------------------------------------------------------------------------
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pend  = '0;
  int          m_starve = 0;
  bit          m_stall  = 0;
  bit          m_pop, m_byp;
  logic        x_we, x_grant, x_ready, x_stall, x_hazard;
  logic [4:0]  x_addr;
  logic [31:0] x_data;
  int          x_count;

  task automatic model_eval();
    ent_t h;
    m_pop = 0; m_byp = 0;
    x_we = 0; x_addr = 0; x_data = 0; x_grant = 0;
    x_ready  = !rst_i && (mq.size() < DEPTH);
    x_count  = mq.size();
    x_stall  = m_stall;
    x_hazard = m_pend[rs_addr_i] | m_pend[rt_addr_i];
    if (!rst_i) begin
      if (m_stall && mq.size() > 0) m_pop = 1;
      else if (wb_we_i && wb_addr_i != 0) begin
        x_we = 1; x_addr = wb_addr_i; x_data = wb_data_i; x_grant = 1;
      end else begin
        x_grant = wb_we_i;
        if (mq.size() > 0) m_pop = 1;
`ifdef REGARB_LLU_BYPASS_EN
        else if (llu_valid_i) m_byp = 1;
`endif
      end
      if (m_pop) begin
        h = mq[0];
        x_we = (h.a != 0); x_addr = h.a; x_data = h.d;
      end
      if (m_byp) begin
        x_we = (llu_addr_i != 0); x_addr = llu_addr_i; x_data = llu_data_i;
      end
    end
  endtask

  task automatic model_commit();
    bit   had_data;
    ent_t e;
    if (rst_i) begin
      mq.delete(); m_pend = '0; m_starve = 0; m_stall = 0;
      return;
    end
    had_data = (mq.size() > 0);
    if (m_pop) begin
      m_pend[mq[0].a] = 1'b0;
      void'(mq.pop_front());
    end
    if (m_byp) m_pend[llu_addr_i] = 1'b0;
    if (llu_valid_i && x_ready && !m_byp) begin
      e.a = llu_addr_i; e.d = llu_data_i;
      mq.push_back(e);
    end
    if (issue_i && issue_rd_i != 0) m_pend[issue_rd_i] = 1'b1;
    m_pend[0] = 1'b0;
    m_starve = (had_data && !m_pop) ? m_starve + 1 : 0;
    if (m_pop) m_stall = 0;
    else if (m_starve == STARVE_LIMIT) m_stall = 1;
  endtask

  task automatic rand_step(input int wb_pct);
    rst_i       = ($urandom_range(0, 199) == 0);
    wb_we_i     = ($urandom_range(0, 99) < wb_pct);
    wb_addr_i   = 5'($urandom_range(0, 7));
    wb_data_i   = $urandom;
    llu_valid_i = ($urandom_range(0, 99) < 40);
    llu_addr_i  = 5'($urandom_range(0, 7));
    llu_data_i  = $urandom;
    issue_i     = ($urandom_range(0, 99) < 30);
    issue_rd_i  = 5'($urandom_range(0, 7));
    rs_addr_i   = 5'($urandom_range(0, 7));
    rt_addr_i   = 5'($urandom_range(0, 7));
    #2;
    model_eval();
    check("rnd_rf_we", rf_we_o, x_we);
    if (x_we) begin
      check("rnd_rf_addr", rf_addr_o, x_addr);
      check("rnd_rf_data", rf_data_o, x_data);
    end
    check("rnd_wb_grant", wb_grant_o, x_grant);
    check("rnd_ready", llu_ready_o, x_ready);
    check("rnd_stall", stall_o, x_stall);
    check("rnd_count", buf_count_o, x_count);
    check("rnd_hazard", hazard_o, x_hazard);
    @(posedge clk_i);
    model_commit();
    #1;
  endtask

  initial begin
    //          rst wbw wba  wbd      lv la   ld      is ird rs cs  we ea  ed      g  r  s  c  h
    vecs[0]  = mk(1, 1, 3, 32'h33, 1, 7,  32'h77, 0, 0,  5, 0,  0, 0,  32'h0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 3, 32'h33, 1, 7,  32'h77, 0, 0,  5, 1,  0, 0,  32'h0,  0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,  0, 0,  32'h0,  0, 0,  5, 1,  0, 0,  32'h0,  0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 1, 3, 32'h33, 1, 9,  32'h99, 1, 9,  9, 1,  1, 3,  32'h33, 1, 1, 0, 0, 0);
    vecs[4]  = mk(0, 1, 3, 32'h34, 0, 0,  32'h0,  0, 0,  9, 1,  1, 3,  32'h34, 1, 1, 0, 1, 1);
    vecs[5]  = mk(0, 1, 3, 32'h35, 0, 0,  32'h0,  0, 0,  9, 1,  1, 3,  32'h35, 1, 1, 0, 1, 1);
    vecs[6]  = mk(0, 1, 3, 32'h36, 0, 0,  32'h0,  0, 0,  9, 1,  1, 3,  32'h36, 1, 1, 0, 1, 1);
    vecs[7]  = mk(0, 1, 3, 32'h37, 0, 0,  32'h0,  0, 0,  9, 1,  1, 3,  32'h37, 1, 1, 0, 1, 1);
    vecs[8]  = mk(0, 1, 3, 32'h38, 0, 0,  32'h0,  0, 0,  9, 1,  1, 9,  32'h99, 0, 1, 1, 1, 1);
    vecs[9]  = mk(0, 1, 3, 32'h38, 0, 0,  32'h0,  0, 0,  9, 1,  1, 3,  32'h38, 1, 1, 0, 0, 0);
    vecs[10] = mk(0, 1, 3, 32'h3A, 1, 4,  32'h44, 0, 0,  4, 1,  1, 3,  32'h3A, 1, 1, 0, 0, 0);
    vecs[11] = mk(0, 1, 3, 32'h3B, 1, 11, 32'hB0, 0, 0,  4, 1,  1, 3,  32'h3B, 1, 1, 0, 1, 0);
    vecs[12] = mk(0, 1, 3, 32'h3C, 1, 12, 32'hC0, 0, 0,  4, 1,  1, 3,  32'h3C, 1, 0, 0, 2, 0);
    vecs[13] = mk(0, 1, 0, 32'hFF, 0, 0,  32'h0,  0, 0,  4, 1,  1, 4,  32'h44, 1, 0, 0, 2, 0);
    vecs[14] = mk(0, 0, 0, 32'h0,  0, 0,  32'h0,  0, 0,  4, 1,  1, 11, 32'hB0, 0, 1, 0, 1, 0);
    vecs[15] = mk(0, 0, 0, 32'h0,  0, 0,  32'h0,  0, 0,  4, 1,  0, 0,  32'h0,  0, 1, 0, 0, 0);
    vecs[16] = mk(0, 1, 3, 32'h3D, 1, 0,  32'h55, 0, 0,  4, 1,  1, 3,  32'h3D, 1, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 32'h0,  0, 0,  32'h0,  0, 0,  4, 1,  0, 0,  32'h0,  0, 1, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,  0, 0,  32'h0,  0, 0,  4, 1,  0, 0,  32'h0,  0, 1, 0, 0, 0);
    vecs[19] = mk(0, 1, 3, 32'h3E, 1, 13, 32'hD0, 1, 13, 13, 1, 1, 3,  32'h3E, 1, 1, 0, 0, 0);
    vecs[20] = mk(1, 1, 3, 32'h3F, 0, 0,  32'h0,  0, 0,  13, 0, 0, 0,  32'h0,  0, 0, 0, 0, 0);
    vecs[21] = mk(1, 1, 3, 32'h3F, 0, 0,  32'h0,  0, 0,  13, 1, 0, 0,  32'h0,  0, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 32'h0,  0, 0,  32'h0,  0, 0,  13, 1, 0, 0,  32'h0,  0, 1, 0, 0, 0);

    set_idle();
    for (int i = 0; i < 23; i++) begin
      rst_i = vecs[i].rst;
      wb_we_i = vecs[i].wb_we; wb_addr_i = vecs[i].wb_addr; wb_data_i = vecs[i].wb_data;
      llu_valid_i = vecs[i].llu_v; llu_addr_i = vecs[i].llu_addr; llu_data_i = vecs[i].llu_data;
      issue_i = vecs[i].issue; issue_rd_i = vecs[i].issue_rd;
      rs_addr_i = vecs[i].rs; rt_addr_i = 5'd0;
      #2;
      check($sformatf("v%0d_rf_we", i), rf_we_o, vecs[i].e_we);
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_rf_addr", i), rf_addr_o, vecs[i].e_addr);
        check($sformatf("v%0d_rf_data", i), rf_data_o, vecs[i].e_data);
      end
      check($sformatf("v%0d_wb_grant", i), wb_grant_o, vecs[i].e_grant);
      check($sformatf("v%0d_ready", i), llu_ready_o, vecs[i].e_ready);
      if (vecs[i].chk_state) begin
        check($sformatf("v%0d_stall", i), stall_o, vecs[i].e_stall);
        check($sformatf("v%0d_count", i), buf_count_o, vecs[i].e_count);
        check($sformatf("v%0d_hazard", i), hazard_o, vecs[i].e_hazard);
      end
      @(posedge clk_i);
      #1;
    end

    // LLU result to r8 with the port idle: same-cycle bypass or one-cycle FIFO latency.
    set_idle();
    llu_valid_i = 1; llu_addr_i = 5'd8; llu_data_i = 32'h0000_00AA;
    #2;
`ifdef REGARB_LLU_BYPASS_EN
    check("r8_byp_we", rf_we_o, 1);
    check("r8_byp_addr", rf_addr_o, 8);
    check("r8_byp_data", rf_data_o, 32'hAA);
    check("r8_byp_count", buf_count_o, 0);
    @(posedge clk_i); #1;
    set_idle(); #2;
    check("r8_byp_after_count", buf_count_o, 0);
    check("r8_byp_after_we", rf_we_o, 0);
`else
    check("r8_buf_we0", rf_we_o, 0);
    check("r8_buf_count0", buf_count_o, 0);
    @(posedge clk_i); #1;
    set_idle(); #2;
    check("r8_buf_count1", buf_count_o, 1);
    check("r8_buf_we1", rf_we_o, 1);
    check("r8_buf_addr1", rf_addr_o, 8);
    check("r8_buf_data1", rf_data_o, 32'hAA);
    @(posedge clk_i); #1;
    #2;
    check("r8_buf_count2", buf_count_o, 0);
    check("r8_buf_we2", rf_we_o, 0);
`endif
    @(posedge clk_i); #1;

    // Randomized traffic against the model; starts from reset.
    set_idle();
    rst_i = 1; #2;
    model_eval();
    @(posedge clk_i);
    model_commit();
    #1;
    for (int c = 0; c < 3000; c++) begin
      rand_step((c < 1500) ? 85 : 45);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
